// File: rtl/i2c_slave_regif.sv
// I2C target: master writes become 6-bit register strobes, master reads fetch from the register read port.
// Bus events act 3 CLK after the pins; no backpressure, SCL phases must last >= 8 CLK.
module i2c_slave_regif #(
  parameter logic [6:0] I2C_ADDR7 = 7'h41,
  parameter logic [1:0] A_TAG     = 2'b00,
  parameter logic [1:0] D_TAG     = 2'b01
) (
  input  logic       CLK,
  input  logic       GSRn,
  input  logic       SCL_I,
  input  logic       SDA_I,
  output logic       SDA_OE,
  output logic       WR_EN,
  output logic [5:0] WR_ADDR,
  output logic [5:0] WR_DATA,
  output logic       RD_EN,
  output logic [5:0] RD_ADDR,
  input  logic [7:0] RD_DATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_RD_LOAD,
    S_RD_BYTE,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  state_t     state;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic [7:0] shift;
  logic [3:0] cnt;
  logic [5:0] ptr;
  logic [1:0] ld_ph;
  logic       ack_on;
  logic       rw;
  logic       rd_first;

  logic       scl_rise, scl_fall, sda_rise, sda_fall;
  logic       start_det, stop_det;
  logic [7:0] rx_byte;

  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= SCL_I;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= SDA_I;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign sda_rise  = sda_s2 & ~sda_d;
  assign sda_fall  = ~sda_s2 & sda_d;
  // SCL must be stable high across the SDA transition for a bus condition.
  assign start_det = sda_fall & scl_s2 & scl_d;
  assign stop_det  = sda_rise & scl_s2 & scl_d;
  assign rx_byte   = {shift[6:0], sda_s2};

  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      state    <= S_IDLE;
      SDA_OE   <= 1'b0;
      WR_EN    <= 1'b0;
      WR_ADDR  <= 6'd0;
      WR_DATA  <= 6'd0;
      RD_EN    <= 1'b0;
      RD_ADDR  <= 6'd0;
      BUSY     <= 1'b0;
      shift    <= 8'd0;
      cnt      <= 4'd0;
      ptr      <= 6'd0;
      ld_ph    <= 2'd0;
      ack_on   <= 1'b0;
      rw       <= 1'b0;
      rd_first <= 1'b0;
    end else begin
      WR_EN <= 1'b0;
      RD_EN <= 1'b0;
      if (stop_det) begin
        state  <= S_IDLE;
        SDA_OE <= 1'b0;
        BUSY   <= 1'b0;
        ack_on <= 1'b0;
      end else if (start_det) begin
        state  <= S_ADDR;
        cnt    <= 4'd0;
        SDA_OE <= 1'b0;
        ack_on <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_ADDR: begin
            if (scl_rise) begin
              shift <= rx_byte;
              if (cnt == 4'd7) begin
                cnt <= 4'd0;
                if (rx_byte[7:1] == I2C_ADDR7) begin
                  BUSY  <= 1'b1;
                  rw    <= rx_byte[0];
                  state <= S_ADDR_ACK;
                end else begin
                  state <= S_IGNORE;
                end
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          S_ADDR_ACK, S_WR_ACK: begin
            // First falling edge pulls SDA low, the second one ends the ACK clock.
            if (scl_fall) begin
              if (!ack_on) begin
                SDA_OE <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                SDA_OE <= 1'b0;
                ack_on <= 1'b0;
                cnt    <= 4'd0;
                if (state == S_ADDR_ACK && rw) begin
                  state    <= S_RD_LOAD;
                  ld_ph    <= 2'd0;
                  rd_first <= 1'b1;
                end else begin
                  state <= S_WR_BYTE;
                end
              end
            end
          end
          S_WR_BYTE: begin
            if (scl_rise) begin
              shift <= rx_byte;
              if (cnt == 4'd7) begin
                cnt   <= 4'd0;
                state <= S_WR_ACK;
                if (rx_byte[7:6] == A_TAG) begin
                  ptr <= rx_byte[5:0];
                end else if (rx_byte[7:6] == D_TAG) begin
                  WR_EN   <= 1'b1;
                  WR_ADDR <= ptr;
                  WR_DATA <= rx_byte[5:0];
                end
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          S_RD_LOAD: begin
            if (ld_ph == 2'd0) begin
              RD_EN   <= 1'b1;
              RD_ADDR <= ptr;
              ld_ph   <= 2'd1;
            end else if (ld_ph == 2'd1) begin
              ld_ph <= 2'd2;
            end else begin
              shift <= RD_DATA;
              state <= S_RD_BYTE;
              // After the address ACK SCL is already low, so the MSB goes out now;
              // after a master ACK SCL is still high and the MSB waits for the fall.
              if (rd_first) begin
                SDA_OE <= ~RD_DATA[7];
                cnt    <= 4'd1;
              end else begin
                cnt <= 4'd0;
              end
            end
          end
          S_RD_BYTE: begin
            if (scl_fall) begin
              if (cnt == 4'd8) begin
                SDA_OE <= 1'b0;
                state  <= S_RD_ACK;
              end else if (cnt == 4'd0) begin
                SDA_OE <= ~shift[7];
                cnt    <= 4'd1;
              end else begin
                shift  <= {shift[6:0], 1'b0};
                SDA_OE <= ~shift[6];
                cnt    <= cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s2) begin
                ptr      <= ptr + 6'd1;
                state    <= S_RD_LOAD;
                ld_ph    <= 2'd0;
                rd_first <= 1'b0;
              end else begin
                state <= S_IGNORE;
              end
            end
          end
          S_IGNORE: SDA_OE <= 1'b0;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_slave_regif.md
Name: i2c_slave_regif

Overview:
- I2C target (slave) front end for PIF firmware. Receives master writes on SCL/SDA and converts them into a 6-bit register write strobe interface. Serves master reads from a 6-bit register read interface.
- Sits between the board SCL/SDA pads (open-drain, external pull-ups) and the flasher register file.
- Byte format matches the shared firmware convention: bits [7:6] are a tag (address or data), bits [5:0] are the payload.

Parameters:
- I2C_ADDR7, 7'h41, 7-bit target address (8'h82 as an address byte with write bit).
- A_TAG, 2'b00, tag value meaning "set register pointer"; tops pass the shared pifdefs value.
- D_TAG, 2'b01, tag value meaning "write data to the register at the pointer"; tops pass the shared pifdefs value.

Ports:
- CLK  in  1  system clock (20 MHz nominal).
- GSRn  in  1  asynchronous active-low reset.
- SCL_I  in  1  SCL pad input; asynchronous to CLK.
- SDA_I  in  1  SDA pad input; asynchronous to CLK.
- SDA_OE  out  1  1 = pull SDA low; 0 = release (pad drives 1'bz).
- WR_EN  out  1  one-CLK register write strobe.
- WR_ADDR  out  6  register index for the write.
- WR_DATA  out  6  write payload.
- RD_EN  out  1  one-CLK read request.
- RD_ADDR  out  6  register index for the read.
- RD_DATA  in  8  read data, valid exactly 1 CLK after RD_EN.
- BUSY  out  1  high from the START that this target addresses until STOP.

Behaviour:
- Reset (GSRn low, asynchronous):
  - SDA_OE=0, WR_EN=0, RD_EN=0, BUSY=0.
  - WR_ADDR=0, WR_DATA=0, RD_ADDR=0.
  - Register pointer=0; state=IDLE; synchronizers preset to 1.
  - Reset during a transfer releases SDA immediately. No strobe is issued for a partial byte.
- Input conditioning:
  - SCL_I and SDA_I each pass through a 2-FF synchronizer plus a 1-FF delay for edge detection.
  - Bus events are therefore seen 3 CLK after the pin changes.
  - SCL high and low phases must each last at least 8 CLK.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - START or repeated START in any state: go to ADDR, clear the bit counter, SDA_OE=0.
  - STOP in any state: go to IDLE, SDA_OE=0, BUSY=0.
- Bit timing:
  - SDA is sampled on SCL rising edges.
  - SDA_OE changes only on the CLK after an SCL falling edge is detected.
- State machine:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first. After the 8th rising edge, compare [7:1] with I2C_ADDR7.
    - Mismatch: go to IGNORE; never drive SDA.
    - Match: BUSY=1, go to ADDR_ACK.
  - ADDR_ACK: SDA_OE=1 on the falling edge after bit 8; release on the next falling edge (end of the 9th clock).
    - R/W=0: go to WR_BYTE.
    - R/W=1: go to RD_LOAD.
  - WR_BYTE: shift 8 bits. On the 8th rising edge, decode the byte:
    - Tag==A_TAG: pointer=byte[5:0]; no strobe.
    - Tag==D_TAG: WR_EN=1 for one CLK, WR_ADDR=pointer, WR_DATA=byte[5:0]. The pointer is not incremented.
    - Any other tag: byte is discarded.
    - In all three cases go to WR_ACK.
  - WR_ACK: ACK exactly as in ADDR_ACK, then return to WR_BYTE. Every byte is ACKed.
  - RD_LOAD: RD_EN=1 for one CLK with RD_ADDR=pointer. Capture RD_DATA on the next CLK into the shift register, then go to RD_BYTE.
    - RD_LOAD completes while SCL is still low after the ACK; the 8 CLK minimum low time guarantees this.
  - RD_BYTE:
    - Drive SDA_OE=~shift[7] from the falling edge that ends the ACK.
    - Shift left on each following falling edge; 8 bits MSB first.
    - Release SDA after the 8th bit's falling edge, then go to RD_ACK.
  - RD_ACK: sample SDA on the 9th rising edge.
    - 0 (ACK): pointer=pointer+1 (wraps 63→0), go to RD_LOAD.
    - 1 (NACK): go to IGNORE.
  - IGNORE: SDA_OE=0; wait for STOP or START.
- Simultaneous events: a START/STOP detected in the same CLK as an SCL edge takes priority; the edge is discarded.
- The pointer persists across transactions and is cleared only by reset.
- WR_EN and RD_EN are never asserted in the same CLK.

Test Plan:
- Write: START, 8'h82, 8'h02, 8'h41, STOP -> 3 ACKs. Exactly one WR_EN with WR_ADDR=2, WR_DATA=1. BUSY returns to 0 after STOP.
- Read: write 8'h82, 8'h00 (pointer=0), STOP; then 8'h83 and read 3 bytes (ACK, ACK, NACK) with RD_DATA model = {2'b00, addr} -> bytes 8'h00, 8'h01, 8'h02. RD_ADDR sequence 0, 1, 2. SDA released after the NACK.
- Wrong address: 8'h84 followed by data -> no ACK, SDA_OE stays 0, no WR_EN, BUSY=0.
- Pointer wrap: set pointer=63, then read 2 bytes -> RD_ADDR 63 then 0.
- Repeated START: write 8'h82, 8'h05, repeated START, 8'h83, read 1 byte with NACK -> RD_ADDR=5, no WR_EN.
- Reset mid-byte: assert GSRn low during bit 4 of a data byte -> SDA_OE=0 immediately, no strobe. After release, the next full write transaction works normally.
